// File: rtl/m_store_rmw.sv
`default_nettype none
// ---------------------------------------------------------------------------
// m_store_rmw : RV32 memory-stage store unit; word stores direct, byte/half via read-modify-write
// Revision    : 1.0
// ---------------------------------------------------------------------------
module m_store_rmw #(
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_con_req,
  input  logic [1:0]    i_con_storesig,
  input  logic [AW-1:0] i_data_addr,
  input  logic [31:0]   i_data_Wdata,
  output logic          o_con_ready,
  output logic          o_con_done,
  output logic          o_con_err,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_re,
  input  logic [31:0]   i_data_memR,
  output logic          o_mem_we,
  output logic [31:0]   o_data_memW
);

  localparam logic [1:0] c_SZ_WORD = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_BYTE = 2'b10;
  localparam logic [1:0] c_SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_MRG  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [1:0]      r_sig;
  logic            r_ready;
  logic            r_mem_re;
  logic            r_mem_we;
  logic            r_done;
  logic            r_err;

  logic            w_accept;
  logic            w_is_err;
  logic [31:0]     w_merged;

  assign w_accept = i_con_req && r_ready;
  assign w_is_err = (i_con_storesig == c_SZ_RSVD) ||
                    ((i_con_storesig == c_SZ_WORD) && (i_data_addr[1:0] != 2'b00)) ||
                    ((i_con_storesig == c_SZ_HALF) && i_data_addr[0]);

  // Strobes and handshake are registered alongside the state so every output
  // is a flop; only the merge data path depends on the memory read bus.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_sig    <= c_SZ_WORD;
      r_ready  <= 1'b1;
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= i_data_addr;
            r_wdata <= i_data_Wdata;
            r_sig   <= i_con_storesig;
            r_ready <= 1'b0;
            if (w_is_err) begin
              r_state <= S_ERR;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (i_con_storesig == c_SZ_WORD) begin
              r_state  <= S_WR;
              r_mem_we <= 1'b1;
              r_done   <= 1'b1;
            end else begin
              r_state  <= S_RD;
              r_mem_re <= 1'b1;
            end
          end
        end
        S_RD: begin
          r_state  <= S_MRG;
          r_mem_we <= 1'b1;
          r_done   <= 1'b1;
        end
        S_WR, S_MRG, S_ERR: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Little-endian lane replacement over the word just read back.
  always_comb begin
    w_merged = i_data_memR;
    if (r_sig == c_SZ_BYTE) begin
      case (r_addr[1:0])
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_sig == c_SZ_HALF) begin
      if (r_addr[1]) begin
        w_merged[31:16] = r_wdata[15:0];
      end else begin
        w_merged[15:0]  = r_wdata[15:0];
      end
    end
  end

  assign o_con_ready = r_ready;
  assign o_con_done  = r_done;
  assign o_con_err   = r_err;
  assign o_mem_re    = r_mem_re;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = {r_addr[AW-1:2], 2'b00};
  assign o_data_memW = (r_state == S_MRG) ? w_merged : r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_m_store_rmw.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_m_store_rmw : directed table-driven bench for the store RMW unit
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_m_store_rmw;

  logic        clk;
  logic        rst_n;
  logic        i_con_req;
  logic [1:0]  i_con_storesig;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_Wdata;
  logic        o_con_ready;
  logic        o_con_done;
  logic        o_con_err;
  logic [31:0] o_mem_addr;
  logic        o_mem_re;
  logic [31:0] i_data_memR;
  logic        o_mem_we;
  logic [31:0] o_data_memW;

  m_store_rmw #(.AW(32)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_con_req      (i_con_req),
    .i_con_storesig (i_con_storesig),
    .i_data_addr    (i_data_addr),
    .i_data_Wdata   (i_data_Wdata),
    .o_con_ready    (o_con_ready),
    .o_con_done     (o_con_done),
    .o_con_err      (o_con_err),
    .o_mem_addr     (o_mem_addr),
    .o_mem_re       (o_mem_re),
    .i_data_memR    (i_data_memR),
    .o_mem_we       (o_mem_we),
    .o_data_memW    (o_data_memW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only memory model: contents preset by the test, writes are logged.
  logic [31:0] mem [0:1023];
  logic [31:0] wr_data_log[$];
  logic [31:0] wr_addr_log[$];
  int          acc_log[$];
  int          cyc      = 0;
  int          done_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_mem_re) i_data_memR <= mem[o_mem_addr[11:2]];
    if (o_mem_we) begin
      wr_data_log.push_back(o_data_memW);
      wr_addr_log.push_back(o_mem_addr);
    end
    if (rst_n && i_con_req && o_con_ready) acc_log.push_back(cyc);
    if (o_con_done) done_cnt <= done_cnt + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic [31:0] a, input logic [31:0] w);
    i_con_storesig = s;
    i_data_addr    = a;
    i_data_Wdata   = w;
    i_con_req      = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  sig;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  // One request through to its done pulse, checking strobes and latency.
  task automatic run_vec(input vec_t v, input int id);
    int nre, nwe, both, done_k;
    logic        got_err;
    logic [31:0] got_data, got_addr;
    string tag;
    tag = $sformatf("v%0d", id);
    nre = 0; nwe = 0; both = 0; done_k = 0; got_err = 1'b0;
    got_data = 32'h0; got_addr = 32'h0;
    mem[v.addr[11:2]] = v.init;
    @(negedge clk);
    chk({tag, "_ready_before"}, {31'h0, o_con_ready}, 32'h1);
    drive(v.sig, v.addr, v.wdata);
    @(negedge clk);
    i_con_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (o_mem_re) nre++;
      if (o_mem_we) begin
        nwe++;
        got_data = o_data_memW;
        got_addr = o_mem_addr;
      end
      if (o_mem_re && o_mem_we) both++;
      if (o_con_done) begin
        done_k  = k;
        got_err = o_con_err;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_latency"}, done_k, v.exp_lat);
    chk({tag, "_err"}, {31'h0, got_err}, {31'h0, v.exp_err});
    chk({tag, "_re_we_overlap"}, both, 0);
    chk({tag, "_re_count"}, nre, (!v.exp_err && v.exp_lat == 2) ? 1 : 0);
    chk({tag, "_we_count"}, nwe, v.exp_err ? 0 : 1);
    if (!v.exp_err) begin
      chk({tag, "_wdata"}, got_data, v.exp_data);
      chk({tag, "_waddr"}, got_addr, {v.addr[31:2], 2'b00});
    end
    @(negedge clk);
    chk({tag, "_ready_after"}, {31'h0, o_con_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, d0, w0, issued, nwe_r, ndone_r;
    logic [1:0]  bs[3];
    logic [31:0] ba[3], bw[3];

    vecs[0]  = '{2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,          32'hDEAD_BEEF, 1'b0, 1};
    vecs[1]  = '{2'b10, 32'h0000_0200, 32'hFFFF_FFAB, 32'h1122_3344, 32'h1122_33AB, 1'b0, 2};
    vecs[2]  = '{2'b10, 32'h0000_0201, 32'hFFFF_FFAB, 32'h1122_3344, 32'h1122_AB44, 1'b0, 2};
    vecs[3]  = '{2'b10, 32'h0000_0202, 32'hFFFF_FFAB, 32'h1122_3344, 32'h11AB_3344, 1'b0, 2};
    vecs[4]  = '{2'b10, 32'h0000_0203, 32'hFFFF_FFAB, 32'h1122_3344, 32'hAB22_3344, 1'b0, 2};
    vecs[5]  = '{2'b01, 32'h0000_0302, 32'h0000_BEEF, 32'h1122_3344, 32'hBEEF_3344, 1'b0, 2};
    vecs[6]  = '{2'b01, 32'h0000_0300, 32'h0000_BEEF, 32'h1122_3344, 32'h1122_BEEF, 1'b0, 2};
    vecs[7]  = '{2'b01, 32'h0000_0401, 32'h0000_BEEF, 32'h0,          32'h0,          1'b1, 1};
    vecs[8]  = '{2'b00, 32'h0000_0402, 32'h1234_5678, 32'h0,          32'h0,          1'b1, 1};
    vecs[9]  = '{2'b11, 32'h0000_0400, 32'h1234_5678, 32'h0,          32'h0,          1'b1, 1};
    vecs[10] = '{2'b01, 32'h0000_0206, 32'hFFFF_5A5A, 32'h0,          32'h5A5A_0000, 1'b0, 2};
    vecs[11] = '{2'b00, 32'h8000_0FFC, 32'h1234_5678, 32'h0,          32'h1234_5678, 1'b0, 1};
    vecs[12] = '{2'b00, 32'h0000_0104, 32'hA5A5_0F0F, 32'h0,          32'hA5A5_0F0F, 1'b0, 1};

    // Reset state, with a request pending that must not be taken.
    rst_n = 1'b0; i_data_memR = 32'h0;
    drive(2'b00, 32'h0000_0100, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, o_con_ready}, 32'h1);
    chk("rst_strobes", {28'h0, o_mem_re, o_mem_we, o_con_done, o_con_err}, 32'h0);
    chk("rst_addr", o_mem_addr, 32'h0);
    chk("rst_wdata", o_data_memW, 32'h0);
    i_con_req = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset during RD of a byte store.
    w0 = wr_data_log.size(); d0 = done_cnt;
    mem[32'h200 >> 2] = 32'h1122_3344;
    @(negedge clk);
    drive(2'b10, 32'h0000_0201, 32'h0000_00CC);
    @(negedge clk);
    i_con_req = 1'b0;
    chk("rstrd_re_before", {31'h0, o_mem_re}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstrd_re_dropped", {31'h0, o_mem_re}, 32'h0);
    chk("rstrd_ready", {31'h0, o_con_ready}, 32'h1);
    nwe_r = 0; ndone_r = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1'b1;
      if (o_mem_we) nwe_r++;
      if (o_con_done) ndone_r++;
    end
    chk("rstrd_no_we", nwe_r + (wr_data_log.size() - w0), 0);
    chk("rstrd_no_done", ndone_r + (done_cnt - d0), 0);
    run_vec(vecs[12], 12);

    // Back-to-back: byte, word, half with request held high throughout.
    bs[0] = 2'b10; ba[0] = 32'h0000_0200; bw[0] = 32'h0000_00AB;
    bs[1] = 2'b00; ba[1] = 32'h0000_0500; bw[1] = 32'hCAFE_F00D;
    bs[2] = 2'b01; ba[2] = 32'h0000_0602; bw[2] = 32'h0000_1234;
    mem[32'h200 >> 2] = 32'h1122_3344;
    mem[32'h600 >> 2] = 32'hAAAA_BBBB;
    a0 = acc_log.size(); d0 = done_cnt; w0 = wr_data_log.size();
    issued = 0;
    @(negedge clk);
    drive(bs[0], ba[0], bw[0]);
    for (int k = 0; k < 20 && issued < 3; k++) begin
      @(negedge clk);
      if (acc_log.size() > a0 + issued) begin
        issued++;
        chk($sformatf("b2b_ready_low%0d", issued), {31'h0, o_con_ready}, 32'h0);
        if (issued == 3) i_con_req = 1'b0;
        else drive(bs[issued], ba[issued], bw[issued]);
      end
    end
    i_con_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_accepts", issued, 3);
    if (issued == 3) begin
      chk("b2b_gap1", acc_log[a0+1] - acc_log[a0], 3);
      chk("b2b_gap2", acc_log[a0+2] - acc_log[a0+1], 2);
    end
    chk("b2b_done_count", done_cnt - d0, 3);
    chk("b2b_write_count", wr_data_log.size() - w0, 3);
    if (wr_data_log.size() - w0 == 3) begin
      chk("b2b_data0", wr_data_log[w0],   32'h1122_33AB);
      chk("b2b_data1", wr_data_log[w0+1], 32'hCAFE_F00D);
      chk("b2b_data2", wr_data_log[w0+2], 32'h1234_BBBB);
      chk("b2b_addr2", wr_addr_log[w0+2], 32'h0000_0600);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
